button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 142 ++++++++++++++
 tb/tb_button_conditioner.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Front-panel button conditioner: synchronizes and debounces set/up/down,
// toggles set mode on each set press, and turns up/down holds into auto-repeat pulses.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int REPEAT_DELAY    = 5000000,
  parameter int REPEAT_RATE     = 1000000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_btn_set,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  output logic       o_set,
  output logic       o_up,
  output logic       o_down,
  output logic [1:0] dbg_state
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2,
    ST_LOCK   = 2'd3
  } state_t;

  // Button vectors are indexed {down, up, set}.
  logic [2:0]      raw;
  logic [2:0]      sync1;
  logic [2:0]      sync2;
  logic [2:0]      deb;
  logic [2:0]      deb_d;
  logic [DB_W-1:0] db_cnt [3];

  assign raw = {i_btn_down, i_btn_up, i_btn_set};

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      for (int i = 0; i < 3; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          // Accept the new level on the edge the count would reach DEBOUNCE_CYCLES.
          deb[i]    <= ~deb[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  state_t           state;
  logic             dir;
  logic [RPT_W-1:0] rpt_cnt;
  logic [2:0]       rise;
  logic             set_next;
  logic             held;

  assign rise      = deb & ~deb_d;
  assign set_next  = o_set ^ rise[0];
  assign held      = dir ? deb[2] : deb[1];
  assign dbg_state = state;

  // Transitions look at the pre-toggle o_set; pulses are masked by the post-toggle
  // value so no pulse ever leaves while set mode is off.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state   <= ST_IDLE;
      dir     <= 1'b0;
      rpt_cnt <= '0;
      o_set   <= 1'b0;
      o_up    <= 1'b0;
      o_down  <= 1'b0;
    end else begin
      o_set  <= set_next;
      o_up   <= 1'b0;
      o_down <= 1'b0;
      if (deb[1] && deb[2]) begin
        state <= ST_LOCK;
      end else begin
        case (state)
          ST_LOCK: begin
            if (!deb[1] && !deb[2]) state <= ST_IDLE;
          end
          ST_IDLE: begin
            if (o_set && (rise[1] ^ rise[2])) begin
              dir     <= rise[2];
              rpt_cnt <= '0;
              state   <= ST_DELAY;
              o_up    <= rise[1] & set_next;
              o_down  <= rise[2] & set_next;
            end
          end
          ST_DELAY: begin
            if (!o_set || !held) begin
              state <= ST_IDLE;
            end else if (rpt_cnt == DELAY_LAST) begin
              rpt_cnt <= '0;
              state   <= ST_REPEAT;
              o_up    <= ~dir & set_next;
              o_down  <= dir & set_next;
            end else begin
              rpt_cnt <= rpt_cnt + 1'b1;
            end
          end
          ST_REPEAT: begin
            if (!o_set || !held) begin
              state <= ST_IDLE;
            end else if (rpt_cnt == RATE_LAST) begin
              rpt_cnt <= '0;
              o_up    <= ~dir & set_next;
              o_down  <= dir & set_next;
            end else begin
              rpt_cnt <= rpt_cnt + 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed scenarios plus random
// button activity, compared cycle by cycle against a window/elapsed-time model.
module tb_button_conditioner;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RR = 3;

  // Raw button vectors are {set, up, down}.
  localparam logic [2:0] NONE  = 3'b000;
  localparam logic [2:0] SET   = 3'b100;
  localparam logic [2:0] UP    = 3'b010;
  localparam logic [2:0] DOWN  = 3'b001;
  localparam logic [2:0] BOTH  = 3'b011;
  localparam logic [2:0] SETUP = 3'b110;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       b_set = 1'b0;
  logic       b_up = 1'b0;
  logic       b_dn = 1'b0;
  logic       o_set;
  logic       o_up;
  logic       o_down;
  logic [1:0] dbg_state;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE(RR)
  ) dut (
    .i_clk(clk),
    .i_rst(rst_n),
    .i_btn_set(b_set),
    .i_btn_up(b_up),
    .i_btn_down(b_dn),
    .o_set(o_set),
    .o_up(o_up),
    .o_down(o_down),
    .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state; n is the edge number since the last reset release.
  logic [2:0] raw_h [0:16383];
  int         n;
  logic [2:0] m_deb;
  logic [2:0] m_deb_prev;
  int         last_tog [3];
  logic       m_set;
  logic       m_active;
  logic       m_dir;
  logic       m_lock;
  int         m_t0;
  logic [2:0] exp_q [$];

  // Observation logs
  int   up_cnt;
  int   dn_cnt;
  int   set_rises;
  int   set_rise_edge;
  int   up_edges [$];
  logic seen_set;
  logic prev_pulse;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_errors++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  // Synchronized value that the debouncer looks at on edge k.
  function automatic logic [2:0] sync_at(input int k);
    return (k >= 3) ? raw_h[k-2] : 3'b000;
  endfunction

  task automatic model_reset();
    n          = 0;
    m_deb      = '0;
    m_deb_prev = '0;
    for (int b = 0; b < 3; b++) last_tog[b] = 0;
    m_set      = 1'b0;
    m_active   = 1'b0;
    m_dir      = 1'b0;
    m_lock     = 1'b0;
    m_t0       = 0;
    exp_q.delete();
    seen_set   = 1'b0;
    prev_pulse = 1'b0;
  endtask

  task automatic model_edge();
    logic [2:0] lvl;
    logic [2:0] prv;
    logic [2:0] nd;
    logic [2:0] s;
    logic       set_next;
    logic       pulse;
    logic       all_diff;
    int         e;
    lvl      = m_deb;
    prv      = m_deb_prev;
    set_next = m_set ^ (lvl[2] & ~prv[2]);
    pulse    = 1'b0;
    if (lvl[1] && lvl[0]) begin
      m_lock   = 1'b1;
      m_active = 1'b0;
    end else if (m_lock) begin
      if (!lvl[1] && !lvl[0]) m_lock = 1'b0;
    end else if (!m_set) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      if ((lvl[1] & ~prv[1]) ^ (lvl[0] & ~prv[0])) begin
        m_active = 1'b1;
        m_dir    = lvl[0] & ~prv[0];
        m_t0     = n;
        pulse    = 1'b1;
      end
    end else if (!(m_dir ? lvl[0] : lvl[1])) begin
      m_active = 1'b0;
    end else begin
      e = n - m_t0;
      if (e == RD || (e > RD && (e - RD) % RR == 0)) pulse = 1'b1;
    end
    m_set = set_next;
    exp_q.push_back({m_set, pulse & set_next & ~m_dir, pulse & set_next & m_dir});
    // A level is accepted once the last DB samples since the previous change all disagree with it.
    nd = m_deb;
    for (int b = 0; b < 3; b++) begin
      if (n - DB >= last_tog[b]) begin
        all_diff = 1'b1;
        for (int j = n - DB + 1; j <= n; j++) begin
          s = sync_at(j);
          if (s[b] == m_deb[b]) all_diff = 1'b0;
        end
        if (all_diff) begin
          nd[b]       = ~m_deb[b];
          last_tog[b] = n;
        end
      end
    end
    m_deb_prev = m_deb;
    m_deb      = nd;
  endtask

  // Driver: one clock cycle with the given raw levels, then scoreboard compare.
  task automatic tick(input logic [2:0] raw);
    logic [2:0] e;
    logic [2:0] obs;
    @(negedge clk);
    b_set = raw[2];
    b_up  = raw[1];
    b_dn  = raw[0];
    raw_h[n+1] = raw;
    @(posedge clk);
    n++;
    model_edge();
    #1;
    e   = exp_q.pop_front();
    obs = {o_set, o_up, o_down};
    check("outputs", obs, e);
    check("up_down_exclusive", o_up & o_down, 0);
    check("no_back_to_back", (o_up | o_down) & prev_pulse, 0);
    prev_pulse = o_up | o_down;
    if (o_up) begin
      up_cnt++;
      up_edges.push_back(n);
    end
    if (o_down) dn_cnt++;
    if (o_set && !seen_set) begin
      set_rises++;
      set_rise_edge = n;
    end
    seen_set = o_set;
  endtask

  task automatic hold(input logic [2:0] raw, input int cycles);
    for (int i = 0; i < cycles; i++) tick(raw);
  endtask

  task automatic clear_logs();
    up_cnt        = 0;
    dn_cnt        = 0;
    set_rises     = 0;
    set_rise_edge = -1;
    up_edges.delete();
  endtask

  // Called just after a tick: reset lands mid-cycle, away from any clock edge.
  task automatic async_reset(input int cycles);
    #2 rst_n = 1'b0;
    #1 check("async_reset", {o_set, o_up, o_down}, 3'b000);
    repeat (cycles) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int         s;
    int         exp_edges [$];
    logic [2:0] lvl;
    int         left [3];

    // Reset
    #1 rst_n = 1'b0;
    #1 check("reset_state", {o_set, o_up, o_down}, 3'b000);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    clear_logs();

    // Clean set press toggles set mode on, second press toggles it off.
    hold(SET, 20);
    check("set_rise_edge", set_rise_edge, 7);
    check("set_rise_count", set_rises, 1);
    hold(NONE, 10);
    check("set_kept_after_release", o_set, 1);
    hold(SET, 20);
    check("set_toggled_off", o_set, 0);
    hold(NONE, 10);

    // Bouncing set press is accepted once, timed from the last rising transition.
    clear_logs();
    for (int i = 0; i < 8; i++) tick((i % 2 == 0) ? SET : NONE);
    s = n + 1;
    hold(SET, 20);
    check("bounce_rise_count", set_rises, 1);
    check("bounce_rise_edge", set_rise_edge, s + 6);
    hold(NONE, 10);

    // Held up: first pulse, delay, then steady repeat until debounced release.
    clear_logs();
    s = n + 1;
    hold(UP, 40);
    hold(NONE, 10);
    exp_edges.delete();
    exp_edges.push_back(s + DB + 2);
    for (int e = DB + 2 + RD; e <= 40 + DB + 1; e += RR) exp_edges.push_back(s + e);
    check("repeat_pulse_count", up_edges.size(), exp_edges.size());
    foreach (exp_edges[i]) begin
      if (i < up_edges.size()) check("repeat_pulse_edge", up_edges[i], exp_edges[i]);
    end
    check("repeat_no_down", dn_cnt, 0);

    // Both held locks out pulses until both are released.
    clear_logs();
    hold(DOWN, 25);
    check("down_into_repeat", dn_cnt, 4);
    hold(BOTH, DB + 2);
    clear_logs();
    hold(BOTH, 15);
    check("lock_no_pulse", up_cnt + dn_cnt, 0);
    hold(DOWN, 15);
    check("lock_up_released", up_cnt + dn_cnt, 0);
    hold(NONE, 10);
    check("lock_both_released", up_cnt + dn_cnt, 0);
    hold(DOWN, 10);
    check("new_down_press", dn_cnt, 1);
    check("new_down_no_up", up_cnt, 0);
    hold(NONE, 10);

    // Presses outside set mode are ignored and not remembered.
    hold(SET, 10);
    hold(NONE, 10);
    check("set_mode_off", o_set, 0);
    clear_logs();
    hold(UP, 30);
    check("up_ignored_set_off", up_cnt, 0);
    hold(SETUP, 10);
    hold(UP, 15);
    check("set_mode_on_again", o_set, 1);
    check("held_up_not_remembered", up_cnt, 0);
    hold(NONE, 10);
    clear_logs();
    hold(UP, 10);
    check("up_repressed", up_cnt, 1);
    hold(NONE, 10);

    // Reset in the middle of a repeat pulse.
    clear_logs();
    hold(UP, 23);
    check("pre_reset_pulse_count", up_cnt, 4);
    check("pre_reset_pulse_live", o_up, 1);
    async_reset(3);
    clear_logs();
    hold(UP, 20);
    check("post_reset_set_off", o_set, 0);
    check("post_reset_no_up", up_cnt, 0);
    hold(NONE, 10);

    // Random button activity, including short bounces and one reset.
    lvl = '0;
    for (int b = 0; b < 3; b++) left[b] = 0;
    for (int c = 0; c < 1600; c++) begin
      for (int b = 0; b < 3; b++) begin
        if (left[b] == 0) begin
          lvl[b]  = 1'($urandom_range(0, 1));
          left[b] = (b == 2) ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 30));
        end
        left[b]--;
      end
      tick(lvl);
      if (c == 800) async_reset(2);
    end

    // Final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
